// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and defaults for the load-use / control hazard unit.
// State encodings, default parameters and the output control bundle live here.
package hazard_ctrl_unit_pkg;

  localparam int HZ_REG_ADDR_WIDTH    = 5;
  localparam int HZ_LOAD_STALL_CYCLES = 1;
  localparam int HZ_PERF_WIDTH        = 32;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LD_STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic ctrl_sel;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_PASS  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, ctrl_sel: 1'b1};
  localparam hz_ctrl_t HZ_CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, ctrl_sel: 1'b0};
  localparam hz_ctrl_t HZ_CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, ctrl_sel: 1'b0};

  // Stall down-counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Used for the stall-cycle performance counter and other perf counters.
module sat_counter
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int WIDTH = HZ_PERF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_full;

  assign w_full = &r_cnt;
  assign cnt    = r_cnt;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !w_full) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / control hazard unit beside the ID stage: stalls PC and IF/ID on a load-use
// hazard for LOAD_STALL_CYCLES cycles, flushes on a taken branch, and counts stall cycles.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH    = HZ_REG_ADDR_WIDTH,
  parameter int LOAD_STALL_CYCLES = HZ_LOAD_STALL_CYCLES,
  parameter int PERF_WIDTH        = HZ_PERF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      IF_ID_rs1_used,
  input  logic                      IF_ID_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      ID_EX_mem_rd_en,
  input  logic                      ID_EX_reg_wr_en,
  input  logic                      EX_branch_taken,
  input  logic                      perf_clr,
  output logic                      pc_write,
  output logic                      IF_ID_write,
  output logic                      IF_ID_flush,
  output logic                      ctrl_sel,
  output logic                      stall_active,
  output logic [PERF_WIDTH-1:0]     perf_stall_cnt
);

  localparam int               CNT_W    = cnt_width(LOAD_STALL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               MULTI    = (LOAD_STALL_CYCLES > 1);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  hz_ctrl_t         w_ctrl;
  logic             w_stall_active;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_hz;
  logic             w_stall_cycle;

  // Unused operands are masked before the compare so X on an idle field cannot leak into hz.
  assign w_rs1_hit = IF_ID_rs1_used ? (ID_EX_rd == IF_ID_rs1) : 1'b0;
  assign w_rs2_hit = IF_ID_rs2_used ? (ID_EX_rd == IF_ID_rs2) : 1'b0;
  assign w_hz      = (ID_EX_mem_rd_en && ID_EX_reg_wr_en) ?
                     ((ID_EX_rd != '0) && (w_rs1_hit || w_rs2_hit)) : 1'b0;

  // State and stall down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HZ_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: the RUN cycle that detects the hazard is the first of the N stall cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      HZ_RUN: begin
        if (EX_branch_taken) begin
          w_state_nxt = HZ_RUN;
          w_cnt_nxt   = '0;
        end else if (w_hz && MULTI) begin
          w_state_nxt = HZ_LD_STALL;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = HZ_RUN;
          w_cnt_nxt   = '0;
        end
      end
      HZ_LD_STALL: begin
        if (EX_branch_taken || (r_cnt <= CNT_ONE)) begin
          w_state_nxt = HZ_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = HZ_LD_STALL;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = HZ_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Mealy outputs; held at pass-through values while reset is asserted.
  always_comb begin
    w_ctrl         = HZ_CTRL_PASS;
    w_stall_active = 1'b0;
    if (!rst_n) begin
      w_ctrl         = HZ_CTRL_PASS;
      w_stall_active = 1'b0;
    end else begin
      case (r_state)
        HZ_RUN: begin
          w_stall_active = 1'b0;
          if (EX_branch_taken) begin
            w_ctrl = HZ_CTRL_FLUSH;
          end else if (w_hz) begin
            w_ctrl = HZ_CTRL_STALL;
          end else begin
            w_ctrl = HZ_CTRL_PASS;
          end
        end
        HZ_LD_STALL: begin
          w_stall_active = 1'b1;
          if (EX_branch_taken) begin
            w_ctrl = HZ_CTRL_FLUSH;
          end else begin
            w_ctrl = HZ_CTRL_STALL;
          end
        end
        default: begin
          w_ctrl         = HZ_CTRL_PASS;
          w_stall_active = 1'b0;
        end
      endcase
    end
  end

  assign pc_write      = w_ctrl.pc_write;
  assign IF_ID_write   = w_ctrl.if_id_write;
  assign IF_ID_flush   = w_ctrl.if_id_flush;
  assign ctrl_sel      = w_ctrl.ctrl_sel;
  assign stall_active  = w_stall_active;
  assign w_stall_cycle = ~w_ctrl.pc_write;

  sat_counter #(
    .WIDTH (PERF_WIDTH)
  ) u_perf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (w_stall_cycle),
    .cnt   (perf_stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: two instances (N=1/32-bit perf, N=4/4-bit perf) share one stimulus stream;
// the driver queues hand-computed expectations and a negedge monitor pops and compares them.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, ld, wr, br, clr;

  logic        a_pw, a_iw, a_fl, a_cs, a_sa;
  logic [31:0] a_perf;
  logic        b_pw, b_iw, b_fl, b_cs, b_sa;
  logic [3:0]  b_perf;

  typedef struct {
    int          dut;
    logic [4:0]  ctl;
    logic [31:0] perf;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(1), .PERF_WIDTH(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .IF_ID_rs1_used(u1), .IF_ID_rs2_used(u2), .ID_EX_rd(rd),
    .ID_EX_mem_rd_en(ld), .ID_EX_reg_wr_en(wr), .EX_branch_taken(br), .perf_clr(clr),
    .pc_write(a_pw), .IF_ID_write(a_iw), .IF_ID_flush(a_fl), .ctrl_sel(a_cs),
    .stall_active(a_sa), .perf_stall_cnt(a_perf)
  );

  hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(4), .PERF_WIDTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .IF_ID_rs1_used(u1), .IF_ID_rs2_used(u2), .ID_EX_rd(rd),
    .ID_EX_mem_rd_en(ld), .ID_EX_reg_wr_en(wr), .EX_branch_taken(br), .perf_clr(clr),
    .pc_write(b_pw), .IF_ID_write(b_iw), .IF_ID_flush(b_fl), .ctrl_sel(b_cs),
    .stall_active(b_sa), .perf_stall_cnt(b_perf)
  );

  // Monitor: compares every queued expectation at the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [4:0]  act_ctl;
    logic [31:0] act_perf;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        act_ctl  = {a_pw, a_iw, a_fl, a_cs, a_sa};
        act_perf = a_perf;
      end else begin
        act_ctl  = {b_pw, b_iw, b_fl, b_cs, b_sa};
        act_perf = {28'd0, b_perf};
      end
      n_checks++;
      if (act_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s dut%0d ctl{pw,iw,fl,cs,sa}: got %b expected %b", e.tag, e.dut, act_ctl, e.ctl);
      end
      n_checks++;
      if (act_perf !== e.perf) begin
        n_fail++;
        $display("FAIL %s dut%0d perf: got %0d expected %0d", e.tag, e.dut, act_perf, e.perf);
      end
    end
  end

  task automatic drive(input logic [4:0] i_rs1, input logic [4:0] i_rs2, input logic i_u1,
                       input logic i_u2, input logic [4:0] i_rd, input logic i_ld, input logic i_wr,
                       input logic i_br, input logic i_clr, input logic i_rstn);
    @(posedge clk);
    #1;
    rs1 = i_rs1; rs2 = i_rs2; u1 = i_u1; u2 = i_u2; rd = i_rd;
    ld = i_ld; wr = i_wr; br = i_br; clr = i_clr; rst_n = i_rstn;
  endtask

  // ld x5 in ID/EX, IF/ID reads x5 and x7.
  task automatic hz(input logic i_br, input logic i_clr, input logic i_rstn);
    drive(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, i_br, i_clr, i_rstn);
  endtask

  // Same IF/ID instruction, ID/EX now holds an all-zero-control bubble.
  task automatic bubble(input logic i_br, input logic i_rstn);
    drive(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, i_br, 1'b0, i_rstn);
  endtask

  task automatic nop(input logic i_rstn);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, i_rstn);
  endtask

  task automatic expect_out(input int dut, input logic pw, input logic fl, input logic cs,
                            input logic sa, input int perf, input string tag);
    exp_t e;
    e.dut  = dut;
    e.ctl  = {pw, pw, fl, cs, sa};
    e.perf = 32'(perf);
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic exp_both(input logic pw, input logic fl, input logic cs, input logic sa_a,
                          input logic sa_b, input int perf_a, input int perf_b, input string tag);
    expect_out(0, pw, fl, cs, sa_a, perf_a, tag);
    expect_out(1, pw, fl, cs, sa_b, perf_b, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    u1 = 1'b0; u2 = 1'b0; ld = 1'b0; wr = 1'b0; br = 1'b0; clr = 1'b0;

    // Reset forces pass-through even with a hazard on the inputs.
    hz(1'b0, 1'b0, 1'b0);  exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "reset_hold_hz");
    hz(1'b0, 1'b0, 1'b0);  exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "reset_hold_hz2");
    nop(1'b1);             exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "release_run");

    // Single load-use hazard: N=1 stalls once, N=4 stalls four cycles.
    hz(1'b0, 1'b0, 1'b1);  exp_both(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "ldu_stall1");
    bubble(1'b0, 1'b1);
    expect_out(0, 1'b1, 1'b0, 1'b1, 1'b0, 1, "ldu_c2");
    expect_out(1, 1'b0, 1'b0, 1'b0, 1'b1, 1, "ldu_c2");
    bubble(1'b0, 1'b1);
    expect_out(0, 1'b1, 1'b0, 1'b1, 1'b0, 1, "ldu_c3");
    expect_out(1, 1'b0, 1'b0, 1'b0, 1'b1, 2, "ldu_c3");
    bubble(1'b0, 1'b1);
    expect_out(0, 1'b1, 1'b0, 1'b1, 1'b0, 1, "ldu_c4");
    expect_out(1, 1'b0, 1'b0, 1'b0, 1'b1, 3, "ldu_c4");
    nop(1'b1);             exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, "ldu_resume");

    // False hazards.
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, "false_ld_x0");
    drive(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, "false_unused_rs2");
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, "false_non_load");
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, "false_no_wr");
    drive(5'd3, 5'bxxxxx, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, "false_x_masked");

    // Taken branch overrides a hazard; no stall follows.
    hz(1'b1, 1'b0, 1'b1);  exp_both(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 4, "br_over_hz");
    nop(1'b1);             exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, "br_no_stall");

    // Branch inside a multi-cycle stall aborts it.
    hz(1'b0, 1'b0, 1'b1);  exp_both(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4, "abort_stall1");
    bubble(1'b1, 1'b1);    exp_both(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 5, "abort_br");
    nop(1'b1);             exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 5, "abort_run");

    // Asynchronous reset in the second stall cycle.
    hz(1'b0, 1'b0, 1'b1);  exp_both(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 5, "rst_stall1");
    bubble(1'b0, 1'b0);    exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "rst_mid_stall");
    nop(1'b0);             exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "rst_hold");
    nop(1'b1);             exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "rst_release");

    // Continuous hazard: every cycle stalls; 4-bit counter saturates at 15.
    for (int k = 0; k < 20; k++) begin
      hz(1'b0, 1'b0, 1'b1);
      expect_out(0, 1'b0, 1'b0, 1'b0, 1'b0, k, "sat_run");
      expect_out(1, 1'b0, 1'b0, 1'b0, ((k % 4) != 0), (k > 15) ? 15 : k, "sat_run");
    end
    hz(1'b0, 1'b1, 1'b1);  exp_both(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 15, "perf_clr_stall");
    hz(1'b0, 1'b0, 1'b1);  exp_both(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, "perf_after_clr");
    nop(1'b1);
    expect_out(0, 1'b1, 1'b0, 1'b1, 1'b0, 1, "tail_c1");
    expect_out(1, 1'b0, 1'b0, 1'b0, 1'b1, 1, "tail_c1");
    nop(1'b1);
    expect_out(0, 1'b1, 1'b0, 1'b1, 1'b0, 1, "tail_c2");
    expect_out(1, 1'b0, 1'b0, 1'b0, 1'b1, 2, "tail_c2");
    nop(1'b1);             exp_both(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3, "tail_run");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
